// File: rtl/otp_access_sequencer.sv
`default_nettype none
// ============================================================================
// otp_access_sequencer : boot autoload of all OTP columns into a shadow, then
// one host read or program-with-verify (bounded retries) at a time.
// Revision 1.0
// ============================================================================
module otp_access_sequencer #(
  parameter int A         = 2,
  parameter int B         = 2,
  parameter int MAX_RETRY = 3,
  localparam int COL_W    = (B > 1) ? $clog2(B) : 1,
  localparam int RW       = $clog2(MAX_RETRY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic             host_write,
  input  logic [COL_W-1:0] host_column,
  input  logic [A-1:0]     host_wdata,
  output logic             rsp_valid,
  output logic [A-1:0]     rsp_rdata,
  output logic             rsp_error,
  output logic [RW-1:0]    rsp_retries,
  output logic             boot_done,
  output logic [A*B-1:0]   shadow,
  output logic             ctl_req,
  output logic [1:0]       ctl_mode,
  output logic [COL_W-1:0] ctl_column,
  output logic [A-1:0]     ctl_wdata,
  input  logic             ctl_done,
  input  logic [A-1:0]     ctl_rdata
);

  localparam logic [2:0] BOOT_RD = 3'd0;
  localparam logic [2:0] IDLE    = 3'd1;
  localparam logic [2:0] PRE_RD  = 3'd2;
  localparam logic [2:0] PROG    = 3'd3;
  localparam logic [2:0] VERIFY  = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_RD   = 2'b01;
  localparam logic [1:0] MODE_PG   = 2'b10;

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(B - 1);
  localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);

  logic [2:0]       r_state;
  logic [COL_W-1:0] r_col;
  logic             r_boot_fin;
  logic             r_write;
  logic [A-1:0]     r_wdata;
  logic [A-1:0]     r_rd;
  logic [RW-1:0]    r_pulses;
  logic [A-1:0]     r_shadow [B];

  logic w_ctl_fire;
  logic w_oor;
  logic w_pre_ok;
  logic w_ver_ok;

  assign w_ctl_fire = ctl_req & ctl_done;
  assign w_pre_ok   = ((ctl_rdata & r_wdata) == r_wdata);
  assign w_ver_ok   = w_pre_ok;

  // When B fills the column index space no index can be out of range.
  generate
    if (B == (1 << COL_W)) begin : g_oor_pow2
      assign w_oor = 1'b0;
    end else begin : g_oor_cmp
      assign w_oor = (host_column >= COL_W'(B));
    end
  endgenerate

  // A controller op starts whenever the state needs one and ctl_req is low,
  // which naturally leaves one idle cycle after every completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= BOOT_RD;
      r_col       <= '0;
      r_boot_fin  <= 1'b0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_rd        <= '0;
      r_pulses    <= '0;
      host_ready  <= 1'b0;
      boot_done   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_retries <= '0;
      ctl_req     <= 1'b0;
      ctl_mode    <= MODE_IDLE;
      ctl_column  <= '0;
      ctl_wdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (w_ctl_fire) begin
        ctl_req   <= 1'b0;
        ctl_mode  <= MODE_IDLE;
        ctl_wdata <= '0;
      end
      case (r_state)
        BOOT_RD: begin
          if (w_ctl_fire) begin
            if (r_col == LAST_COL) r_boot_fin <= 1'b1;
            else                   r_col      <= r_col + 1'b1;
          end else if (!ctl_req) begin
            if (r_boot_fin) begin
              boot_done  <= 1'b1;
              host_ready <= 1'b1;
              r_state    <= IDLE;
            end else begin
              ctl_req    <= 1'b1;
              ctl_mode   <= MODE_RD;
              ctl_column <= r_col;
            end
          end
        end
        IDLE: begin
          if (host_valid && host_ready) begin
            host_ready <= 1'b0;
            r_col      <= host_column;
            r_write    <= host_write;
            r_wdata    <= host_wdata;
            r_pulses   <= '0;
            if (w_oor) begin
              rsp_valid   <= 1'b1;
              rsp_error   <= 1'b1;
              rsp_rdata   <= '0;
              rsp_retries <= '0;
              r_state     <= RESP;
            end else begin
              ctl_req    <= 1'b1;
              ctl_mode   <= MODE_RD;
              ctl_column <= host_column;
              r_state    <= PRE_RD;
            end
          end
        end
        PRE_RD: begin
          if (w_ctl_fire) begin
            r_rd <= ctl_rdata;
            if (!r_write || w_pre_ok) begin
              rsp_valid   <= 1'b1;
              rsp_error   <= 1'b0;
              rsp_rdata   <= ctl_rdata;
              rsp_retries <= r_pulses;
              r_state     <= RESP;
            end else begin
              r_state <= PROG;
            end
          end
        end
        PROG: begin
          if (w_ctl_fire) begin
            r_state <= VERIFY;
          end else if (!ctl_req) begin
            // Only burn bits still reading 0; already-set bits are never pulsed.
            ctl_req    <= 1'b1;
            ctl_mode   <= MODE_PG;
            ctl_column <= r_col;
            ctl_wdata  <= r_wdata & ~r_rd;
            r_pulses   <= r_pulses + 1'b1;
          end
        end
        VERIFY: begin
          if (w_ctl_fire) begin
            r_rd <= ctl_rdata;
            if (w_ver_ok || (r_pulses >= RETRY_MAX)) begin
              rsp_valid   <= 1'b1;
              rsp_error   <= ~w_ver_ok;
              rsp_rdata   <= ctl_rdata;
              rsp_retries <= r_pulses;
              r_state     <= RESP;
            end else begin
              r_state <= PROG;
            end
          end else if (!ctl_req) begin
            ctl_req    <= 1'b1;
            ctl_mode   <= MODE_RD;
            ctl_column <= r_col;
          end
        end
        RESP: begin
          host_ready <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= BOOT_RD;
      endcase
    end
  end

  // Every completed array read refreshes the shadow copy of that column.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < B; c++) r_shadow[c] <= '0;
    end else if (w_ctl_fire && (ctl_mode == MODE_RD)) begin
      for (int c = 0; c < B; c++) begin
        if (ctl_column == COL_W'(c)) r_shadow[c] <= ctl_rdata;
      end
    end
  end

  generate
    for (genvar g = 0; g < B; g++) begin : g_shadow
      assign shadow[g*A +: A] = r_shadow[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_otp_access_sequencer.sv
`default_nettype none
// ============================================================================
// tb_otp_access_sequencer : directed bench with a cell-controller model.
// Revision 1.0
// ============================================================================
module tb_otp_access_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Main instance: A=2, B=2, MAX_RETRY=3
  logic       host_valid = 1'b0, host_write = 1'b0;
  logic [0:0] host_column = 1'b0;
  logic [1:0] host_wdata = 2'b00;
  logic       host_ready, rsp_valid, rsp_error, boot_done, ctl_req;
  logic [1:0] rsp_rdata, rsp_retries, ctl_mode, ctl_wdata;
  logic [3:0] shadow;
  logic [0:0] ctl_column;
  logic       ctl_done = 1'b0;
  logic [1:0] ctl_rdata = 2'b00;

  otp_access_sequencer #(.A(2), .B(2), .MAX_RETRY(3)) dut (
    .clk(clk), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready), .host_write(host_write),
    .host_column(host_column), .host_wdata(host_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .rsp_retries(rsp_retries), .boot_done(boot_done), .shadow(shadow),
    .ctl_req(ctl_req), .ctl_mode(ctl_mode), .ctl_column(ctl_column),
    .ctl_wdata(ctl_wdata), .ctl_done(ctl_done), .ctl_rdata(ctl_rdata)
  );

  // Second instance: B=1, used for the out-of-range column case
  logic       hv2 = 1'b0, hw2 = 1'b0;
  logic [0:0] hc2 = 1'b0;
  logic [1:0] hwd2 = 2'b00;
  logic       hr2, rv2, re2, bd2, creq2;
  logic [1:0] rd2, rr2, cm2, cwd2, sh2;
  logic [0:0] ccol2;
  logic       cdone2 = 1'b0;
  logic [1:0] crd2 = 2'b00;

  otp_access_sequencer #(.A(2), .B(1), .MAX_RETRY(3)) dut2 (
    .clk(clk), .reset(reset),
    .host_valid(hv2), .host_ready(hr2), .host_write(hw2),
    .host_column(hc2), .host_wdata(hwd2),
    .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_error(re2),
    .rsp_retries(rr2), .boot_done(bd2), .shadow(sh2),
    .ctl_req(creq2), .ctl_mode(cm2), .ctl_column(ccol2),
    .ctl_wdata(cwd2), .ctl_done(cdone2), .ctl_rdata(crd2)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cell controller model: done one cycle after the first cycle of ctl_req.
  logic [1:0] mem [2];
  bit         burn_en = 1'b1;
  int         rd_ops = 0, pg_ops = 0, bad_mask = 0, age = 0, age2 = 0;
  logic [1:0] last_pg = 2'b00;

  always @(negedge clk) begin
    if (ctl_done) begin
      ctl_done = 1'b0;
      age = 0;
    end else if (!ctl_req) begin
      age = 0;
    end else if (age == 0) begin
      age = 1;
    end else begin
      ctl_done = 1'b1;
      if (ctl_mode == 2'b01) begin
        ctl_rdata = mem[ctl_column];
        rd_ops++;
      end else if (ctl_mode == 2'b10) begin
        pg_ops++;
        last_pg = ctl_wdata;
        if ((ctl_wdata & mem[ctl_column]) != 2'b00) bad_mask++;
        if (burn_en) mem[ctl_column] = mem[ctl_column] | ctl_wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (cdone2) begin
      cdone2 = 1'b0;
      age2 = 0;
    end else if (!creq2) begin
      age2 = 0;
    end else if (age2 == 0) begin
      age2 = 1;
    end else begin
      cdone2 = 1'b1;
      crd2 = 2'b11;
    end
  end

  task automatic wait_boot(input string tag);
    int n = 0;
    while (!(boot_done && bd2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic host_req(input logic wr, input logic [0:0] col, input logic [1:0] wd,
                          output int lat, output logic [1:0] rd, output logic err,
                          output logic [1:0] ret);
    int n = 0;
    while (!host_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", 32'd1, 32'd0);
    host_valid = 1'b1; host_write = wr; host_column = col; host_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    host_valid = 1'b0;
    chk("req_at_T1", {30'd0, ctl_req, host_ready}, 32'h2);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) chk("rsp_timeout", 32'd1, 32'd0);
    rd = rsp_rdata; err = rsp_error; ret = rsp_retries;
  endtask

  initial begin
    int lat, pg0, n;
    logic [1:0] rd, ret;
    logic err;
    bit saw_rsp;
    mem[0] = 2'b01;
    mem[1] = 2'b10;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_outputs", {25'd0, host_ready, boot_done, rsp_valid, ctl_req, ctl_mode, rsp_error},
        32'd0);
    chk("rst_shadow", {28'd0, shadow}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("boot_first_req", {28'd0, ctl_req, ctl_mode, ctl_column}, 32'b1010);
    wait_boot("boot");
    chk("boot_shadow", {28'd0, shadow}, 32'b1001);
    chk("boot_ready", {30'd0, boot_done, host_ready}, 32'b11);
    chk("boot_reads", rd_ops, 32'd2);

    // Read column 1
    pg0 = pg_ops;
    host_req(1'b0, 1'b1, 2'b00, lat, rd, err, ret);
    chk("rd_latency", lat, 32'd3);
    chk("rd_rsp", {27'd0, rd, err, ret}, {27'd0, 2'b10, 1'b0, 2'b00});

    // Write already-programmed bits
    host_req(1'b1, 1'b0, 2'b01, lat, rd, err, ret);
    chk("wr_noop_latency", lat, 32'd3);
    chk("wr_noop_rsp", {27'd0, rd, err, ret}, {27'd0, 2'b01, 1'b0, 2'b00});
    chk("wr_noop_no_prog", pg_ops - pg0, 32'd0);

    // Write 11 to column 1 (holds 10): one pulse with mask 01
    host_req(1'b1, 1'b1, 2'b11, lat, rd, err, ret);
    chk("wr1_latency", lat, 32'd9);
    chk("wr1_rsp", {27'd0, rd, err, ret}, {27'd0, 2'b11, 1'b0, 2'b01});
    chk("wr1_mask", {30'd0, last_pg}, 32'b01);
    chk("wr1_shadow_hi", {30'd0, shadow[3:2]}, 32'b11);
    @(negedge clk);
    chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);

    // Blank column that never burns: exhaust retries
    mem[0] = 2'b00;
    burn_en = 1'b0;
    pg0 = pg_ops;
    host_req(1'b1, 1'b0, 2'b01, lat, rd, err, ret);
    chk("wrfail_latency", lat, 32'd21);
    chk("wrfail_rsp", {27'd0, rd, err, ret}, {27'd0, 2'b00, 1'b1, 2'b11});
    chk("wrfail_pulses", pg_ops - pg0, 32'd3);
    chk("mask_never_overlaps", bad_mask, 32'd0);

    // Out-of-range column on the B=1 instance
    n = 0;
    while (!hr2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("oor_ready_timeout", 32'd1, 32'd0);
    hv2 = 1'b1; hc2 = 1'b1; hw2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    hv2 = 1'b0;
    chk("oor_rsp_T1", {26'd0, rv2, re2, rd2, rr2}, {26'd0, 1'b1, 1'b1, 2'b00, 2'b00});
    chk("oor_no_req", {31'd0, creq2}, 32'd0);
    @(negedge clk);
    chk("oor_no_req2", {31'd0, creq2}, 32'd0);

    // Reset during PROG
    host_valid = 1'b1; host_write = 1'b1; host_column = 1'b0; host_wdata = 2'b01;
    @(posedge clk);
    @(negedge clk);
    host_valid = 1'b0;
    n = 0;
    while (!(ctl_req && ctl_mode == 2'b10) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reached_prog", {31'd0, ctl_req && ctl_mode == 2'b10}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", {28'd0, ctl_req, boot_done, host_ready, rsp_valid}, 32'd0);
    saw_rsp = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reboot_first_req", {28'd0, ctl_req, ctl_mode, ctl_column}, 32'b1010);
    n = 0;
    while (!boot_done && n < 200) begin
      if (rsp_valid) saw_rsp = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("reboot_done", {31'd0, boot_done}, 32'd1);
    chk("reboot_no_rsp", {31'd0, saw_rsp}, 32'd0);
    chk("reboot_shadow", {28'd0, shadow}, 32'b1100);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
